cordic_vector: RTL and testbench

- Pipelined CORDIC in vectoring mode. Converts a rectangular sample (X, Y) to polar form: gain-scaled magnitude and a 32-bit phase.
- This is the inverse of the rotation-mode NCO path. Output phase uses the same phase-word format as the NCO accumulator: 2^32 = 360 deg, 0x4000_0000 = 90 deg.
- Sits after the rotator/I-Q path. Used for demodulation, phase detection and closed-loop checking of the NCO.

---
 rtl/cordic_pkg.sv | 57 +++++
 rtl/cordic_vec_stage.sv | 65 ++++++
 rtl/cordic_vector.sv | 120 ++++++++++++
 tb/tb_cordic_vector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg : shared constants for the vectoring CORDIC (arctangent table,
//              phase-word landmarks, CORDIC gain).
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cordic_pkg;

    // Phase word: 2^32 = 360 degrees
    localparam logic [31:0] PH_90   = 32'h4000_0000;
    localparam logic [31:0] PH_180  = 32'h8000_0000;
    localparam logic [31:0] PH_270  = 32'hC000_0000;

    // CORDIC gain An ~ 1.64676 in unsigned Q1.15
    localparam logic [15:0] AN_Q15  = 16'd53961;

    // Fractional bits carried below the magnitude LSB inside the pipeline
    localparam int          GUARD_W = 4;

    // round(atan(2^-i) * 2^32 / (2*pi)), i = 0..23
    function automatic logic [31:0] atan_lut(input int i);
        logic [31:0] r_val;
        r_val = '0;
        case (i)
            0:  r_val = 32'h2000_0000;
            1:  r_val = 32'h12E4_051E;
            2:  r_val = 32'h09FB_385B;
            3:  r_val = 32'h0511_11D4;
            4:  r_val = 32'h028B_0D43;
            5:  r_val = 32'h0145_D7E1;
            6:  r_val = 32'h00A2_F61E;
            7:  r_val = 32'h0051_7C55;
            8:  r_val = 32'h0028_BE53;
            9:  r_val = 32'h0014_5F2F;
            10: r_val = 32'h000A_2F98;
            11: r_val = 32'h0005_17CC;
            12: r_val = 32'h0002_8BE6;
            13: r_val = 32'h0001_45F3;
            14: r_val = 32'h0000_A2FA;
            15: r_val = 32'h0000_517D;
            16: r_val = 32'h0000_28BE;
            17: r_val = 32'h0000_145F;
            18: r_val = 32'h0000_0A30;
            19: r_val = 32'h0000_0518;
            20: r_val = 32'h0000_028C;
            21: r_val = 32'h0000_0146;
            22: r_val = 32'h0000_00A3;
            23: r_val = 32'h0000_0051;
            default: r_val = '0;
        endcase
        return r_val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_vec_stage.sv
// ---------------------------------------------------------------------------
// cordic_vec_stage : one registered vectoring micro-rotation (drives Y to 0).
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cordic_vec_stage #(
    parameter int            W     = 26,
    parameter int            PW    = 32,
    parameter int            SHIFT = 0,
    parameter logic [PW-1:0] ATAN  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_y,
    input  logic [PW-1:0]       i_z,
    output logic                o_valid,
    output logic signed [W-1:0] o_x,
    output logic signed [W-1:0] o_y,
    output logic [PW-1:0]       o_z
);

    logic signed [W-1:0] w_xs;
    logic signed [W-1:0] w_ys;
    logic                w_ypos;

    logic                r_valid;
    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic [PW-1:0]       r_z;

    assign w_xs   = i_x >>> SHIFT;
    assign w_ys   = i_y >>> SHIFT;
    assign w_ypos = ~i_y[W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            r_valid <= i_valid;
            if (w_ypos) begin
                r_x <= i_x + w_ys;
                r_y <= i_y - w_xs;
                r_z <= i_z + ATAN;
            end else begin
                r_x <= i_x - w_ys;
                r_y <= i_y + w_xs;
                r_z <= i_z - ATAN;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;

endmodule

`default_nettype wire

// File: rtl/cordic_vector.sv
// ---------------------------------------------------------------------------
// cordic_vector : pipelined vectoring CORDIC, (X,Y) -> (An*|r|, atan2 phase).
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cordic_vector
    import cordic_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DW     = 22,
    parameter int PW     = 32,
    parameter int STAGES = 16
) (
    input  logic                   CLK_12MHZ,
    input  logic                   RESET,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] Xin,
    input  logic signed [IN_W-1:0] Yin,
    output logic                   out_valid,
    output logic [DW-1:0]          mag_out,
    output logic [PW-1:0]          phase_out
);

    localparam int                     c_IW    = DW + GUARD_W;
    localparam logic signed [c_IW-1:0] c_ROUND = c_IW'(2 ** (GUARD_W - 1));

    logic signed [c_IW-1:0] w_xe;
    logic signed [c_IW-1:0] w_ye;
    logic signed [c_IW-1:0] w_xr;

    logic signed [c_IW-1:0] w_x [0:STAGES];
    logic signed [c_IW-1:0] w_y [0:STAGES];
    logic [PW-1:0]          w_z [0:STAGES];
    logic                   w_v [0:STAGES];

    logic                   r_v0;
    logic signed [c_IW-1:0] r_x0;
    logic signed [c_IW-1:0] r_y0;
    logic [PW-1:0]          r_z0;

    logic                   r_out_valid;
    logic [DW-1:0]          r_mag;
    logic [PW-1:0]          r_phase;

    // Sign-extend before any negation so -2^(IN_W-1) has headroom
    assign w_xe = {{(DW - IN_W){Xin[IN_W-1]}}, Xin, {GUARD_W{1'b0}}};
    assign w_ye = {{(DW - IN_W){Yin[IN_W-1]}}, Yin, {GUARD_W{1'b0}}};

    always_ff @(posedge CLK_12MHZ or posedge RESET) begin
        if (RESET) begin
            r_v0 <= 1'b0;
            r_x0 <= '0;
            r_y0 <= '0;
            r_z0 <= '0;
        end else begin
            r_v0 <= in_valid;
            if (Xin[IN_W-1]) begin
                r_x0 <= -w_xe;
                r_y0 <= -w_ye;
                r_z0 <= PW'(PH_180);
            end else begin
                r_x0 <= w_xe;
                r_y0 <= w_ye;
                r_z0 <= '0;
            end
        end
    end

    assign w_x[0] = r_x0;
    assign w_y[0] = r_y0;
    assign w_z[0] = r_z0;
    assign w_v[0] = r_v0;

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            cordic_vec_stage #(
                .W     (c_IW),
                .PW    (PW),
                .SHIFT (g),
                .ATAN  (PW'(atan_lut(g)))
            ) u_stage (
                .clk     (CLK_12MHZ),
                .rst     (RESET),
                .i_valid (w_v[g]),
                .i_x     (w_x[g]),
                .i_y     (w_y[g]),
                .i_z     (w_z[g]),
                .o_valid (w_v[g+1]),
                .o_x     (w_x[g+1]),
                .o_y     (w_y[g+1]),
                .o_z     (w_z[g+1])
            );
        end
    endgenerate

    // Round away the guard bits; final X is non-negative after pre-rotation
    assign w_xr = w_x[STAGES] + c_ROUND;

    always_ff @(posedge CLK_12MHZ or posedge RESET) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_mag       <= '0;
            r_phase     <= '0;
        end else begin
            r_out_valid <= w_v[STAGES];
            if (w_v[STAGES]) begin
                r_mag   <= DW'(w_xr >>> GUARD_W);
                r_phase <= w_z[STAGES];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign mag_out   = r_mag;
    assign phase_out = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_cordic_vector.sv
// ---------------------------------------------------------------------------
// tb_cordic_vector : scoreboard bench for cordic_vector against a real-math
//                    polar reference and fixed corner values.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cordic_vector;
    import cordic_pkg::*;

    localparam int LAT = 18;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] Xin;
    logic signed [15:0] Yin;
    logic               out_valid;
    logic [21:0]        mag_out;
    logic [31:0]        phase_out;

    cordic_vector #(
        .IN_W   (16),
        .DW     (22),
        .PW     (32),
        .STAGES (16)
    ) dut (
        .CLK_12MHZ (clk),
        .RESET     (rst),
        .in_valid  (in_valid),
        .Xin       (Xin),
        .Yin       (Yin),
        .out_valid (out_valid),
        .mag_out   (mag_out),
        .phase_out (phase_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        longint      mag;
        longint      mtol;
        logic [31:0] ph;
        bit          chk_ph;
        int          nco_k;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        e;
    logic [31:0] d;
    bit          exp_v;
    logic [31:0] nco_ph [0:12];
    bit          nco_seen [0:12];
    logic [31:0] step;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        n_checks++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    task automatic send(input int x, input int y, input longint emag, input longint mtol,
                        input logic [31:0] eph, input bit chk_ph, input int nco_k);
        exp_t t;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        Xin      = 16'(x);
        Yin      = 16'(y);
        t.cyc    = cyc;
        t.mag    = emag;
        t.mtol   = mtol;
        t.ph     = eph;
        t.chk_ph = chk_ph;
        t.nco_k  = nco_k;
        sb.push_back(t);
    endtask

    task automatic send_model(input int x, input int y, input int nco_k);
        real rx, ry, r, ph, an;
        rx = x;
        ry = y;
        an = real'(AN_Q15) / 32768.0;
        r  = $sqrt(rx * rx + ry * ry);
        ph = $atan2(ry, rx) * 4294967296.0 / (2.0 * 3.141592653589793);
        if (ph < 0.0) ph = ph + 4294967296.0;
        send(x, y, longint'(r * an), 8, 32'(longint'(ph)), 1'b1, nco_k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            Xin      = 16'($urandom);
            Yin      = 16'($urandom);
        end
    endtask

    task automatic rand_pt(output int x, output int y);
        x = int'($urandom_range(5000, 30000));
        y = int'($urandom_range(5000, 30000));
        if ($urandom_range(0, 1) == 1) x = -x;
        if ($urandom_range(0, 1) == 1) y = -y;
    endtask

    // Output monitor: every cycle the expected out_valid is derived from the scoreboard
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc + LAT < cyc) begin
            check("timeout", 0, 1);
            void'(sb.pop_front());
        end
        exp_v = (sb.size() > 0) && (sb[0].cyc + LAT == cyc);
        if (rst) begin
            check("rst_valid", longint'(out_valid), 0);
            check("rst_mag",   longint'(mag_out),   0);
            check("rst_phase", longint'(phase_out), 0);
        end else begin
            check("out_valid", longint'(out_valid), longint'(exp_v));
            if (exp_v) begin
                e = sb.pop_front();
                if (out_valid) begin
                    check("mag", longint'(mag_out), e.mag, e.mtol);
                    if (e.chk_ph) begin
                        d = phase_out - e.ph;
                        check("phase", longint'(e.ph) + longint'($signed(d)), longint'(e.ph), 65536);
                    end
                    if (e.nco_k >= 0) begin
                        nco_ph[e.nco_k]   = phase_out;
                        nco_seen[e.nco_k] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int x, y;
        rst      = 1'b1;
        in_valid = 1'b0;
        Xin      = '0;
        Yin      = '0;
        for (int k = 0; k <= 12; k++) begin
            nco_seen[k] = 1'b0;
            nco_ph[k]   = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Quadrant points
        send(10000, 0,      16468, 4, 32'h0000_0000, 1'b1, -1);
        send(0,     10000,  16468, 4, PH_90,         1'b1, -1);
        send(-10000, 0,     16468, 4, PH_180,        1'b1, -1);
        send(0,     -10000, 16468, 4, PH_270,        1'b1, -1);
        idle(LAT + 4);

        // Isolated pulse
        send_model(12000, 5000, -1);
        idle(LAT + 4);

        // Corner amplitudes
        send(-32768, -32768, 76313, 8, 32'hA000_0000, 1'b1, -1);
        send(32767,  0,      53959, 4, 32'h0000_0000, 1'b1, -1);
        send(0,      0,      0,     0, 32'h0000_0000, 1'b0, -1);
        idle(LAT + 2);

        // 20 back-to-back random samples
        for (int i = 0; i < 20; i++) begin
            rand_pt(x, y);
            send_model(x, y, -1);
        end

        // NCO round-trip, 30 degree steps
        for (int k = 0; k <= 12; k++) begin
            x = int'(10000.0 * $cos(real'(k) * 3.141592653589793 / 6.0));
            y = int'(10000.0 * $sin(real'(k) * 3.141592653589793 / 6.0));
            send(x, y, 16468, 8, 32'(k * 32'h1555_5555), 1'b1, k);
        end

        // Alternating valid pattern
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                rand_pt(x, y);
                send_model(x, y, -1);
            end else begin
                idle(1);
            end
        end
        idle(LAT + 2);

        // Reset while results are in flight and emerging
        for (int i = 0; i < 25; i++) begin
            rand_pt(x, y);
            send_model(x, y, -1);
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(30);
        send_model(-7000, 9000, -1);
        idle(LAT + 8);

        check("sb_drained", longint'(sb.size()), 0);
        for (int k = 1; k <= 12; k++) begin
            if (nco_seen[k] && nco_seen[k-1]) begin
                step = nco_ph[k] - nco_ph[k-1];
                check("nco_step", longint'(step), longint'(32'h1555_5555), 65536);
            end else begin
                check("nco_seen", 0, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
